reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 107 ++++++++++
 tb/tb_reset_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release sequencer.
// Releases STAGES reset outputs one by one, GAP_CYCLES apart.
module reset_sequencer #(
   parameter int STAGES     = 3,
   parameter int GAP_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_rst_i,
   output logic [STAGES-1:0] stage_rst_n_o,
   output logic              busy_o,
   output logic              seq_done_o,
   output logic [7:0]        reset_count_o
);

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      GAP  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES - 1);
   localparam logic [2:0] LAST_IDX = 3'(STAGES - 1);

   state_t            state;
   logic [5:0]        gap_cnt;
   logic [2:0]        stage_idx;
   logic              boot_q;
   logic [STAGES-1:0] rel_mask;

   // One-hot mask of the stage released when the current gap expires
   always_comb begin
      rel_mask = '0;
      for (int i = 0; i < STAGES; i++) begin
         rel_mask[i] = (stage_idx == 3'(i));
      end
   end

   // Release FSM: boot reset wins in every state, then timed release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= HOLD;
         gap_cnt       <= '0;
         stage_idx     <= '0;
         stage_rst_n_o <= '0;
         busy_o        <= 1'b0;
         seq_done_o    <= 1'b0;
      end else if (boot_rst_i) begin
         state         <= HOLD;
         gap_cnt       <= '0;
         stage_idx     <= '0;
         stage_rst_n_o <= '0;
         busy_o        <= 1'b0;
         seq_done_o    <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               state         <= GAP;
               gap_cnt       <= '0;
               stage_idx     <= '0;
               stage_rst_n_o <= '0;
               busy_o        <= 1'b1;
               seq_done_o    <= 1'b0;
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  stage_rst_n_o <= stage_rst_n_o | rel_mask;
                  gap_cnt       <= '0;
                  stage_idx     <= stage_idx + 3'd1;
                  if (stage_idx == LAST_IDX) begin
                     state      <= DONE;
                     busy_o     <= 1'b0;
                     seq_done_o <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 6'd1;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state         <= HOLD;
               gap_cnt       <= '0;
               stage_idx     <= '0;
               stage_rst_n_o <= '0;
               busy_o        <= 1'b0;
               seq_done_o    <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of boot reset rising edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         boot_q        <= 1'b0;
         reset_count_o <= '0;
      end else begin
         boot_q <= boot_rst_i;
         if (boot_rst_i && !boot_q && reset_count_o != 8'hFF) begin
            reset_count_o <= reset_count_o + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized self-checking bench for reset_sequencer.
// Two instances: default 3x8 and the 1x1 corner.
module tb_reset_sequencer;

   localparam int SA = 3;
   localparam int GA = 8;
   localparam int SB = 1;
   localparam int GB = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          boot = 1'b0;
   logic [SA-1:0] stage_a;
   logic          busy_a, done_a;
   logic [7:0]    cnt_a;
   logic [SB-1:0] stage_b;
   logic          busy_b, done_b;
   logic [7:0]    cnt_b;

   int checks = 0;
   int errors = 0;

   // Model: edges elapsed since the sequence left reset hold
   bit run_a = 0, run_b = 0;
   int t_a = 0, t_b = 0;
   bit m_prev = 0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   reset_sequencer #(.STAGES(SA), .GAP_CYCLES(GA)) dut_a (
      .clk(clk), .rst_n(rst_n), .boot_rst_i(boot),
      .stage_rst_n_o(stage_a), .busy_o(busy_a),
      .seq_done_o(done_a), .reset_count_o(cnt_a)
   );

   reset_sequencer #(.STAGES(SB), .GAP_CYCLES(GB)) dut_b (
      .clk(clk), .rst_n(rst_n), .boot_rst_i(boot),
      .stage_rst_n_o(stage_b), .busy_o(busy_b),
      .seq_done_o(done_b), .reset_count_o(cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_stage(input bit run, input int t,
                                             input int s, input int g);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < s; i++) begin
         if (run && t >= (i + 1) * g) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_done(input bit run, input int t,
                                            input int s, input int g);
      return {31'b0, (run && t >= s * g)};
   endfunction

   function automatic logic [31:0] exp_busy(input bit run, input int t,
                                            input int s, input int g);
      return {31'b0, (run && t < s * g)};
   endfunction

   task automatic model_reset();
      run_a = 0; run_b = 0; t_a = 0; t_b = 0;
      m_prev = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      if (boot && !m_prev && m_cnt < 255) m_cnt++;
      m_prev = boot;
      if (boot) begin
         run_a = 0; run_b = 0;
      end else begin
         if (!run_a) begin run_a = 1; t_a = 0; end
         else if (t_a < 100000) t_a++;
         if (!run_b) begin run_b = 1; t_b = 0; end
         else if (t_b < 100000) t_b++;
      end
   endtask

   task automatic check_all();
      chk("stage_a", {29'b0, stage_a}, exp_stage(run_a, t_a, SA, GA));
      chk("busy_a", {31'b0, busy_a}, exp_busy(run_a, t_a, SA, GA));
      chk("done_a", {31'b0, done_a}, exp_done(run_a, t_a, SA, GA));
      chk("cnt_a", {24'b0, cnt_a}, m_cnt);
      chk("stage_b", {31'b0, stage_b}, exp_stage(run_b, t_b, SB, GB));
      chk("busy_b", {31'b0, busy_b}, exp_busy(run_b, t_b, SB, GB));
      chk("done_b", {31'b0, done_b}, exp_done(run_b, t_b, SB, GB));
      chk("cnt_b", {24'b0, cnt_b}, m_cnt);
   endtask

   // One clock edge: model follows, outputs checked, back at negedge
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         if (rst_n) model_edge();
         #1;
         check_all();
         @(negedge clk);
      end
   endtask

   task automatic async_pulse();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      boot = 1'b1;
      #2;
      model_reset();
      check_all();
      chk("rst_stage", {29'b0, stage_a}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(5);
      chk("cnt_after_boot", {24'b0, cnt_a}, 32'd1);

      boot = 1'b0;
      step(1);
      chk("busy_at_E", {31'b0, busy_a}, 32'd1);
      step(11);
      chk("stage_E11", {29'b0, stage_a}, 32'b001);
      boot = 1'b1;
      step(1);
      chk("abort_stage", {29'b0, stage_a}, 32'b000);
      chk("abort_busy", {31'b0, busy_a}, 32'd0);
      chk("abort_cnt", {24'b0, cnt_a}, 32'd2);

      boot = 1'b0;
      step(1);
      chk("b_busy_E", {31'b0, busy_b}, 32'd1);
      chk("b_stage_E", {31'b0, stage_b}, 32'd0);
      step(1);
      chk("b_stage_E1", {31'b0, stage_b}, 32'd1);
      chk("b_done_E1", {31'b0, done_b}, 32'd1);
      step(6);
      chk("stage_E7", {29'b0, stage_a}, 32'b000);
      step(1);
      chk("stage_E8", {29'b0, stage_a}, 32'b001);
      step(8);
      chk("stage_E16", {29'b0, stage_a}, 32'b011);
      step(7);
      chk("busy_E23", {31'b0, busy_a}, 32'd1);
      step(1);
      chk("stage_E24", {29'b0, stage_a}, 32'b111);
      chk("done_E24", {31'b0, done_a}, 32'd1);
      chk("busy_E24", {31'b0, busy_a}, 32'd0);

      step(1000);
      chk("stable_stage", {29'b0, stage_a}, 32'b111);

      async_pulse();
      chk("async_cnt", {24'b0, cnt_a}, 32'd0);
      chk("async_done", {31'b0, done_a}, 32'd0);
      step(30);

      rst_n = 1'b0;
      boot = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      chk("first_edge_cnt", {24'b0, cnt_a}, 32'd1);

      for (int i = 0; i < 3000; i++) begin
         boot = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 399) == 0) async_pulse();
         step(1);
      end

      for (int i = 0; i < 300; i++) begin
         boot = 1'b1;
         step(1);
         boot = 1'b0;
         step(1);
      end
      chk("sat_cnt", {24'b0, cnt_a}, 32'd255);
      boot = 1'b1;
      step(1);
      boot = 1'b0;
      step(1);
      chk("sat_hold", {24'b0, cnt_a}, 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
